instr_fetch_ctrl: RTL and testbench

- Fetch sequencer for the synchronous-read instruction memory (address sampled on posedge, word valid the following cycle).
- Owns the PC, issues one fetch per cycle and tracks the read in flight.
- Buffers returned words in a small skid FIFO so decode can back-pressure with valid/ready.
- Handles taken-branch redirects, flushing and misaligned-target faults.

---
 rtl/instr_fetch_ctrl_if.sv | 17 +
 rtl/instr_fetch_ctrl.sv | 77 +++++++
 tb/tb_instr_fetch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: fetch-side bundle between the sequencer, instruction memory, decode and branch unit.
interface instr_fetch_ctrl_if #(parameter int XLEN = 32);
    logic            fetch_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_word;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            fault;
    modport master (input fetch_en, imem_word, if_ready, br_taken, br_target,
                    output imem_addr, if_valid, if_instr, if_pc, fault);
    modport slave  (output fetch_en, imem_word, if_ready, br_taken, br_target,
                    input imem_addr, if_valid, if_instr, if_pc, fault);
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer for a synchronous-read imem with a skid FIFO toward decode,
// branch redirects and a sticky misaligned-target fault.
module instr_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h4,
    parameter int              DEPTH    = 2
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_ctrl_if.master bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, inflight_pc_q;
    logic            inflight_q;
    logic [XLEN-1:0] fifo_pc [DEPTH];
    logic [XLEN-1:0] fifo_ins [DEPTH];
    logic [AW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [CW:0]     occ;
    logic            pop, push, redirect, misaligned, issue;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction
    // Occupancy counts the word in flight so the FIFO can never be overrun.
    always_comb begin
        redirect   = bus.br_taken & (state_q != FAULT);
        misaligned = redirect & (bus.br_target[1:0] != 2'b00);
        pop        = bus.if_valid & bus.if_ready;
        push       = inflight_q & !redirect;
        occ        = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue      = (state_q == RUN) & bus.fetch_en & !bus.br_taken & (occ < (CW+1)'(DEPTH));
        state_d    = (misaligned || state_q == FAULT) ? FAULT : bus.fetch_en ? RUN : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]  <= '0;
                fifo_ins[i] <= '0;
            end
        end else begin
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
            pc_q <= issue ? pc_q + XLEN'(4) : (redirect & !misaligned) ? bus.br_target : pc_q;
            if (push) begin
                fifo_pc[tail_q]  <= inflight_pc_q;
                fifo_ins[tail_q] <= bus.imem_word;
            end
            if (redirect) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= pop ? nxt(head_q) : head_q;
                tail_q  <= push ? nxt(tail_q) : tail_q;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = count_q != '0;
    assign bus.if_instr  = fifo_ins[head_q];
    assign bus.if_pc     = fifo_pc[head_q];
    assign bus.fault     = state_q == FAULT;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: per-cycle directed vector table for instr_fetch_ctrl plus async-reset
// and first-valid latency sequences.
module tb_instr_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    instr_fetch_ctrl_if #(.XLEN(32)) bus();
    instr_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] wf(input logic [31:0] a);
        case (a)
            32'd4:   return 32'h0010_0093;
            32'd8:   return 32'h0020_0113;
            32'd12:  return 32'h0000_0033;
            32'd16:  return 32'h0000_0000;
            32'd20:  return 32'h0030_0193;
            default: return {16'hBEEF, a[15:0]};
        endcase
    endfunction
    initial bus.imem_word = '0;
    always @(posedge clk) bus.imem_word <= wf(bus.imem_addr);
    typedef struct {
        logic r, fe, rdy, br;
        logic [31:0] tgt, a;
        logic v;
        logic [31:0] p, i;
        logic f;
    } vec_t;
    vec_t tbl[$];
    task automatic add(input logic r, fe, rdy, br, input logic [31:0] tgt, a,
                       input logic v, input logic [31:0] p, i, input logic f);
        tbl.push_back('{r, fe, rdy, br, tgt, a, v, p, i, f});
    endtask
    task automatic n(input logic fe, rdy, input logic [31:0] a, input logic v,
                     input logic [31:0] p, i);
        add(1, fe, rdy, 0, 0, a, v, p, i, 0);
    endtask
    task automatic rst_row();
        add(0, 0, 0, 0, 0, 32'd4, 0, 0, 0, 0);
    endtask
    task automatic chk(input string nm, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic ramp();
        n(1, 1, 4, 0, 0, 0);
        n(1, 1, 4, 0, 0, 0);
        n(1, 1, 8, 0, 0, 0);
        n(1, 1, 12, 1, 4, 32'h0010_0093);
    endtask
    int lat;
    initial begin
        bus.fetch_en = 0; bus.if_ready = 0; bus.br_taken = 0; bus.br_target = 0;
        rst_row(); rst_row();
        // streaming at one instruction per cycle
        ramp();
        n(1, 1, 16, 1, 8, 32'h0020_0113);
        n(1, 1, 20, 1, 12, 32'h0000_0033);
        n(1, 1, 24, 1, 16, 32'h0000_0000);
        n(1, 1, 28, 1, 20, 32'h0030_0193);
        rst_row();
        // back-pressure saturates the FIFO and stalls the PC
        ramp();
        for (int k = 0; k < 5; k++) n(1, 0, 16, 1, 8, 32'h0020_0113);
        n(1, 1, 16, 1, 8, 32'h0020_0113);
        n(1, 1, 20, 1, 12, 32'h0000_0033);
        n(1, 1, 24, 1, 16, 32'h0000_0000);
        n(1, 1, 28, 1, 20, 32'h0030_0193);
        rst_row();
        // redirect with 12 and 16 buffered
        ramp();
        n(1, 1, 16, 1, 8, 32'h0020_0113);
        n(1, 0, 20, 1, 12, 32'h0000_0033);
        add(1, 1, 0, 1, 32'd20, 20, 1, 12, 32'h0000_0033, 0);
        n(1, 1, 20, 0, 0, 0);
        n(1, 1, 24, 0, 0, 0);
        n(1, 1, 28, 1, 20, 32'h0030_0193);
        n(1, 1, 32, 1, 24, 32'hBEEF_0018);
        rst_row();
        // misaligned redirect faults; later redirects are ignored
        ramp();
        add(1, 1, 1, 1, 32'h16, 16, 1, 8, 32'h0020_0113, 0);
        add(1, 1, 1, 0, 0, 16, 0, 0, 0, 1);
        add(1, 1, 1, 1, 32'd8, 16, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 16, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 16, 0, 0, 0, 1);
        rst_row();
        // fetch_en drop after pc 8 issues
        n(1, 1, 4, 0, 0, 0);
        n(1, 1, 4, 0, 0, 0);
        n(1, 1, 8, 0, 0, 0);
        n(0, 1, 12, 1, 4, 32'h0010_0093);
        n(0, 1, 12, 1, 8, 32'h0020_0113);
        n(0, 1, 12, 0, 0, 0);
        n(1, 1, 12, 0, 0, 0);
        n(1, 1, 12, 0, 0, 0);
        n(1, 1, 16, 0, 0, 0);
        n(1, 1, 20, 1, 12, 32'h0000_0033);
        rst_row();
        // redirect in IDLE to the top of the address space, then wrap
        add(1, 0, 1, 1, 32'hFFFF_FFFC, 4, 0, 0, 0, 0);
        n(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        n(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        n(1, 1, 32'h0, 0, 0, 0);
        n(1, 1, 32'h4, 1, 32'hFFFF_FFFC, 32'hBEEF_FFFC);
        n(1, 1, 32'h8, 1, 32'h0, 32'hBEEF_0000);
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst_n = tbl[k].r; bus.fetch_en = tbl[k].fe; bus.if_ready = tbl[k].rdy;
            bus.br_taken = tbl[k].br; bus.br_target = tbl[k].tgt;
            #1;
            chk($sformatf("addr[%0d]", k), bus.imem_addr, tbl[k].a);
            chk($sformatf("valid[%0d]", k), 32'(bus.if_valid), 32'(tbl[k].v));
            chk($sformatf("fault[%0d]", k), 32'(bus.fault), 32'(tbl[k].f));
            if (tbl[k].v || !tbl[k].r) begin
                chk($sformatf("pc[%0d]", k), bus.if_pc, tbl[k].p);
                chk($sformatf("instr[%0d]", k), bus.if_instr, tbl[k].i);
            end
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_rst_addr", bus.imem_addr, 32'd4);
        chk("async_rst_valid", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        rst_n = 1; bus.fetch_en = 1; bus.if_ready = 1; bus.br_taken = 0;
        lat = 0;
        while (!bus.if_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("first_valid_cycles", 32'(lat), 32'd3);
        chk("first_valid_pc", bus.if_pc, 32'd4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
